// File: rtl/nes_joypad.sv
// rtl/nes_joypad.sv - NES $4016/$4017 standard controller pair fed from USB HID keycodes
module nes_joypad #(
    parameter bit KEYMAP_P2_EN = 1'b1
) (
    input  logic        cpu_clk,
    input  logic        reset_n,
    input  logic        cpu_en,
    input  logic [15:0] bus_addr,
    input  logic        bus_wr,
    input  logic [7:0]  bus_din,
    input  logic [31:0] keycode,
    output logic [7:0]  bus_out,
    output logic        bus_hit,
    output logic [7:0]  pad1_dbg
);

    localparam logic [15:0] ADDR_JOY1 = 16'h4016;
    localparam logic [15:0] ADDR_JOY2 = 16'h4017;

    logic [31:0] k1_q, k2_q;
    logic [7:0]  pad1_q, pad1_d, pad2_q, pad2_d;
    logic [7:0]  sh1_q, sh1_d, sh2_q, sh2_d;
    logic        strobe_q, strobe_d;
    logic        rollover, accept;
    logic        addr_joy1, addr_joy2, rd_joy1, rd_joy2;
    logic        unused_din;

    // Bit order A,B,Select,Start,Up,Down,Left,Right; opposing directions cancel.
    function automatic logic [7:0] map_keys(input logic [31:0] kc, input logic p2);
        logic [7:0] b;
        logic [7:0] k;
        b = 8'h00;
        for (int i = 0; i < 4; i++) begin
            k = kc[8*i +: 8];
            if (!p2) begin
                case (k)
                    8'h1B: b[0] = 1'b1;
                    8'h1D: b[1] = 1'b1;
                    8'h2B: b[2] = 1'b1;
                    8'h28: b[3] = 1'b1;
                    8'h52: b[4] = 1'b1;
                    8'h51: b[5] = 1'b1;
                    8'h50: b[6] = 1'b1;
                    8'h4F: b[7] = 1'b1;
                    default: ;
                endcase
            end else begin
                case (k)
                    8'h0E: b[0] = 1'b1;
                    8'h0D: b[1] = 1'b1;
                    8'h14: b[2] = 1'b1;
                    8'h08: b[3] = 1'b1;
                    8'h1A: b[4] = 1'b1;
                    8'h16: b[5] = 1'b1;
                    8'h04: b[6] = 1'b1;
                    8'h07: b[7] = 1'b1;
                    default: ;
                endcase
            end
        end
        if (b[4] && b[5]) b[5:4] = 2'b00;
        if (b[6] && b[7]) b[7:6] = 2'b00;
        return b;
    endfunction

    assign unused_din = ^bus_din[7:1];

    assign rollover  = (k2_q[7:0] == 8'h01) || (k2_q[15:8] == 8'h01) ||
                       (k2_q[23:16] == 8'h01) || (k2_q[31:24] == 8'h01);
    assign accept    = (k1_q == k2_q) && !rollover;

    assign addr_joy1 = (bus_addr == ADDR_JOY1);
    assign addr_joy2 = (bus_addr == ADDR_JOY2);
    assign bus_hit   = (addr_joy1 || addr_joy2) && bus_wr;
    assign rd_joy1   = cpu_en && bus_wr && addr_joy1;
    assign rd_joy2   = cpu_en && bus_wr && addr_joy2;
    assign pad1_dbg  = pad1_q;

    always_comb begin
        bus_out = 8'h00;
        if (bus_hit) begin
            bus_out = {7'b0100000, addr_joy2 ? sh2_q[0] : sh1_q[0]};
        end
    end

    always_comb begin
        pad1_d   = pad1_q;
        pad2_d   = pad2_q;
        strobe_d = strobe_q;
        sh1_d    = sh1_q;
        sh2_d    = sh2_q;
        if (accept) begin
            pad1_d = map_keys(k2_q, 1'b0);
            pad2_d = KEYMAP_P2_EN ? map_keys(k2_q, 1'b1) : 8'h00;
        end
        if (cpu_en && !bus_wr && addr_joy1) begin
            strobe_d = bus_din[0];
        end
        // Strobe high keeps the shifters transparent; low freezes them until read.
        if (strobe_q) begin
            sh1_d = pad1_q;
            sh2_d = pad2_q;
        end else begin
            if (rd_joy1) sh1_d = {1'b1, sh1_q[7:1]};
            if (rd_joy2) sh2_d = {1'b1, sh2_q[7:1]};
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (!reset_n) begin
            k1_q     <= 32'h0;
            k2_q     <= 32'h0;
            pad1_q   <= 8'h00;
            pad2_q   <= 8'h00;
            sh1_q    <= 8'h00;
            sh2_q    <= 8'h00;
            strobe_q <= 1'b0;
        end else begin
            k1_q     <= keycode;
            k2_q     <= k1_q;
            pad1_q   <= pad1_d;
            pad2_q   <= pad2_d;
            sh1_q    <= sh1_d;
            sh2_q    <= sh2_d;
            strobe_q <= strobe_d;
        end
    end

endmodule

// File: tb/tb_nes_joypad.sv
// tb/tb_nes_joypad.sv - directed-vector bench for nes_joypad
module tb_nes_joypad;

    logic        cpu_clk = 1'b0;
    logic        reset_n;
    logic        cpu_en;
    logic [15:0] bus_addr;
    logic        bus_wr;
    logic [7:0]  bus_din;
    logic [31:0] keycode;
    logic [7:0]  bus_out;
    logic        bus_hit;
    logic [7:0]  pad1_dbg;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] d;
    logic       h;
    logic [9:0] exp_seq;

    nes_joypad #(.KEYMAP_P2_EN(1'b1)) dut (
        .cpu_clk  (cpu_clk),
        .reset_n  (reset_n),
        .cpu_en   (cpu_en),
        .bus_addr (bus_addr),
        .bus_wr   (bus_wr),
        .bus_din  (bus_din),
        .keycode  (keycode),
        .bus_out  (bus_out),
        .bus_hit  (bus_hit),
        .pad1_dbg (pad1_dbg)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge cpu_clk);
        #1;
    endtask

    task automatic bus_idle();
        bus_addr = 16'h0000;
        bus_wr   = 1'b1;
        cpu_en   = 1'b1;
        bus_din  = 8'h00;
    endtask

    task automatic rd(input logic [15:0] a, input logic en, output logic [7:0] dat, output logic hit);
        @(negedge cpu_clk);
        bus_addr = a;
        bus_wr   = 1'b1;
        cpu_en   = en;
        #1;
        dat = bus_out;
        hit = bus_hit;
        tick(1);
        bus_idle();
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] v, output logic hit);
        @(negedge cpu_clk);
        bus_addr = a;
        bus_wr   = 1'b0;
        cpu_en   = 1'b1;
        bus_din  = v;
        #1;
        hit = bus_hit;
        tick(1);
        bus_idle();
    endtask

    initial begin
        bus_idle();
        keycode = 32'h0;
        reset_n = 1'b0;
        tick(3);
        reset_n = 1'b1;

        // Reset state
        chk("rst_pad1", pad1_dbg, 8'h00);
        rd(16'h4016, 1'b1, d, h);
        chk("rst_rd4016", d, 8'h40);
        chk("rst_hit", h, 1'b1);

        // Latch and shift with Start held
        keycode = 32'h00000028;
        tick(4);
        wr(16'h4016, 8'h01, h);
        wr(16'h4016, 8'h00, h);
        exp_seq = 10'b1100001000;
        for (int i = 0; i < 10; i++) begin
            rd(16'h4016, 1'b1, d, h);
            chk($sformatf("shift_%0d", i), d, {7'b0100000, exp_seq[i]});
        end

        // Strobe held with X pressed, then released
        wr(16'h4016, 8'h01, h);
        keycode = 32'h0000001B;
        tick(4);
        for (int i = 0; i < 3; i++) begin
            rd(16'h4016, 1'b1, d, h);
            chk($sformatf("strobe_x_%0d", i), d, 8'h41);
        end
        keycode = 32'h0;
        tick(4);
        rd(16'h4016, 1'b1, d, h);
        chk("strobe_rel", d, 8'h40);
        wr(16'h4016, 8'h00, h);

        // Keymap, latency, SOCD and rollover
        tick(4);
        keycode = 32'h4F50521B;
        tick(2);
        chk("lat_2cyc", pad1_dbg, 8'h00);
        tick(1);
        chk("lat_3cyc", pad1_dbg, 8'h11);
        keycode = 32'h01010101;
        tick(4);
        chk("rollover_all", pad1_dbg, 8'h11);
        keycode = 32'h00000128;
        tick(4);
        chk("rollover_one", pad1_dbg, 8'h11);
        keycode = 32'h00005150;
        tick(4);
        chk("down_left", pad1_dbg, 8'h60);
        keycode = 32'h00005152;
        tick(4);
        chk("socd_ud", pad1_dbg, 8'h00);
        keycode = 32'h00001D2B;
        tick(4);
        chk("b_select", pad1_dbg, 8'h06);
        keycode = 32'h0;
        tick(4);
        chk("release", pad1_dbg, 8'h00);

        // Glitch filter: alternating words are never accepted
        for (int i = 0; i < 10; i++) begin
            keycode = (i % 2 == 0) ? 32'h0000041B : 32'h0;
            tick(1);
            chk($sformatf("glitch_%0d", i), pad1_dbg, 8'h00);
        end

        // Player 2 A
        keycode = 32'h0000000E;
        tick(4);
        chk("p2_only_pad1", pad1_dbg, 8'h00);
        wr(16'h4016, 8'h01, h);
        wr(16'h4016, 8'h00, h);
        rd(16'h4017, 1'b1, d, h);
        chk("p2_rd4017", d, 8'h41);
        chk("p2_hit4017", h, 1'b1);
        rd(16'h4016, 1'b1, d, h);
        chk("p2_rd4016", d, 8'h40);

        // DMA cycles do not shift
        keycode = 32'h00000028;
        tick(4);
        wr(16'h4016, 8'h01, h);
        wr(16'h4016, 8'h00, h);
        for (int i = 0; i < 3; i++) begin
            rd(16'h4016, 1'b1, d, h);
            chk($sformatf("dma_pre_%0d", i), d, 8'h40);
        end
        for (int i = 0; i < 5; i++) begin
            rd(16'h4016, 1'b0, d, h);
            chk($sformatf("dma_off_%0d", i), d, 8'h41);
        end
        rd(16'h4016, 1'b1, d, h);
        chk("dma_post_start", d, 8'h41);
        rd(16'h4016, 1'b1, d, h);
        chk("dma_post_up", d, 8'h40);

        // Reset mid-sequence
        keycode = 32'h0000001B;
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
        chk("midrst_pad1", pad1_dbg, 8'h00);
        rd(16'h4016, 1'b1, d, h);
        chk("midrst_rd", d, 8'h40);
        tick(5);
        chk("midrst_pad_x", pad1_dbg, 8'h01);
        rd(16'h4016, 1'b1, d, h);
        chk("midrst_nostrobe", d, 8'h40);

        // Address decode
        rd(16'h4015, 1'b1, d, h);
        chk("dec4015_out", d, 8'h00);
        chk("dec4015_hit", h, 1'b0);
        rd(16'h4018, 1'b1, d, h);
        chk("dec4018_out", d, 8'h00);
        chk("dec4018_hit", h, 1'b0);
        wr(16'h4017, 8'h01, h);
        chk("wr4017_hit", h, 1'b0);
        tick(2);
        rd(16'h4016, 1'b1, d, h);
        chk("wr4017_nostrobe", d, 8'h40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nes_joypad.md
# nes_joypad

Standard-controller port pair for the NES core, mapped at CPU addresses $4016/$4017. It converts the USB keyboard keycode word from the Nios soft-core into two 8-button NES pad states and serves them through the stock strobe/serial-shift protocol on the CPU bus. It sits beside the system RAM, PRG ROM and PPU as a bus peripheral. Its read data goes into the data-bus read mux.

## Interface
Parameters:
- KEYMAP_P2_EN, 1, enable the player-2 key mapping; when 0, $4017 reads as no buttons pressed.

Ports:
- cpu_clk  in  1  CPU clock, the same clock the T65 core runs on; the only clock in this block.
- reset_n  in  1  synchronous, active-low reset.
- cpu_en  in  1  CPU bus cycle valid (driven by ~DMA); bus side effects occur only when this is 1.
- bus_addr  in  16  CPU address (bits [15:0] of the core's address bus).
- bus_wr  in  1  R_W_n from the CPU: 1 = read, 0 = write.
- bus_din  in  8  CPU write data.
- keycode  in  32  four USB HID keycodes, byte 0 in [7:0]; 0x00 means an empty slot.
- bus_out  out  8  read data for $4016/$4017.
- bus_hit  out  1  high when bus_addr is $4016 or $4017 and bus_wr = 1; selects bus_out in the data-bus mux.
- pad1_dbg  out  8  current player-1 button snapshot, for LEDs.

## Operation
- Button bit order, which is also the shift order (bit0 leaves first): A, B, Select, Start, Up, Down, Left, Right.
- Player-1 keymap: X 0x1B = A, Z 0x1D = B, Tab 0x2B = Select, Enter 0x28 = Start, Up 0x52, Down 0x51, Left 0x50, Right 0x4F.
- Player-2 keymap: K 0x0E = A, J 0x0D = B, Q 0x14 = Select, E 0x08 = Start, W 0x1A = Up, S 0x16 = Down, A 0x04 = Left, D 0x07 = Right.
- A button is pressed if any of the four slots holds its keycode. Duplicate keycodes across slots are harmless.
- Input capture:
  - keycode is registered twice (k1, then k2).
  - A sample is accepted only when k1 == k2, i.e. the word has been stable for 2 consecutive cycles.
  - When accepted, the mapped result updates the snapshot registers pad1/pad2.
- Rollover: if any byte of an accepted word is 0x01 (ErrorRollOver), the snapshot is left unchanged.
- Opposing directions: Up+Down both pressed reports both as 0; Left+Right likewise.
- Strobe register:
  - A write to $4016 with cpu_en = 1 and bus_wr = 0 loads strobe <= bus_din[0].
  - Writes to $4017 are ignored; that address belongs to the APU.
- Shift registers sh1/sh2:
  - While strobe = 1, they reload from pad1/pad2 every cycle.
  - On the cycle strobe holds 0 after having been 1, they hold the last loaded value. This is the latch.
- Read of $4016 (cpu_en = 1, bus_wr = 1, address match):
  - bus_out = {7'b0100000, sh1[0]}, with open-bus bits fixed at $40.
  - If strobe = 0, sh1 <= {1'b1, sh1[7:1]} at the cycle end.
  - $4017 behaves the same using sh2.
  - Reads with strobe = 1 return pad bit A and do not shift.
- After 8 shifts the register holds all 1s, so every further read returns D0 = 1.
- When the address does not match or the cycle is a write, bus_out = 8'h00 and bus_hit = 0.

## Timing
- Reset (reset_n = 0 at a cpu_clk edge) clears:
  - k1, k2, pad1, pad2, sh1 and sh2 to 0.
  - strobe to 0.
  - Therefore pad1_dbg = 0, and bus_out = $40 on a $4016 read.
- bus_out and bus_hit are combinational from bus_addr, bus_wr and registered state. Read data is valid within the same CPU cycle: zero-wait.
- The shift and strobe update happen at the cpu_clk edge that ends the bus cycle. The next read sees the new bit.
- Keycode-to-snapshot latency is 3 cycles: k1, then k2 with compare, then pad.
- When strobe = 1, sh reflects a pad change 1 cycle after pad updates.
- A snapshot change while strobe = 0 does not alter an in-progress shift sequence.
- cpu_en = 0: no shift and no strobe update. bus_hit still decodes the address, but the mux ignores it during DMA.
- Each enabled read cycle at the address shifts once. The CPU must not stall on these addresses with cpu_en held high.
- A reset in the middle of a read sequence takes effect at that edge. The next read returns 0 for A.

## Test plan
- Latch and shift: reset, keycode = 0x00000028 (Start), wait 4 cycles, write $4016 = 1 then 0, do 10 reads of $4016 -> D0 sequence 0,0,0,1,0,0,0,0,1,1; each read byte is $40/$41.
- Strobe held: with strobe = 1 and X pressed, 3 reads of $4016 -> $41,$41,$41; release X, wait 4 cycles, next read -> $40.
- SOCD and multi-key: keycode = 0x4F50521B (Right, Left, Up, A) -> pad1_dbg = 8'h11; keycode 0x01010101 -> pad1_dbg stays 8'h11.
- Player 2 and glitch filter: keycode toggles between 0x00000004 and 0 every cycle -> pad2 unchanged; hold 0x0000000E -> after latch, the first $4017 read returns $41 and $4016 returns $40.
- DMA and reset: during a shift sequence, assert cpu_en = 0 for 5 read cycles -> no shift occurs; then assert reset_n = 0 mid-sequence -> the next read returns $40 and strobe = 0.
- Decode: a read at $4015 or $4018 gives bus_hit = 0, bus_out = 0; a write of $01 to $4017 leaves strobe at 0.
